mem_ctrl: RTL

//  Memory controller below the MEM stage. Serialises 32-bit instruction fetches (IF)
//  and load/store requests (MEM) onto a single byte-wide synchronous RAM port.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_byte_assembler.sv | 33 +++
 rtl/mem_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;
   typedef enum logic {OWN_IF, OWN_MEM} owner_e;
   typedef enum logic [1:0] {
      MT_NONE = 2'd0,
      MT_BYTE = 2'd1,
      MT_HALF = 2'd2,
      MT_WORD = 2'd3
   } mem_type_e;

   // RAM read data appears this many cycles after the address is driven
   localparam int unsigned RAM_LAT = 1;

   function automatic logic [2:0] len_of(input mem_type_e mt);
      case (mt)
         MT_BYTE: len_of = 3'd1;
         MT_HALF: len_of = 3'd2;
         default: len_of = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline (IF/MEM) request/response signals plus the byte-wide RAM port.
interface mem_ctrl_if #(parameter int unsigned ADDR_W = 32);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_cancel;
   logic              if_done;
   logic [31:0]       if_inst;

   logic              mem_read;
   logic              mem_write;
   logic [1:0]        mem_type;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_done;
   logic [31:0]       mem_rdata;
   logic              stall_req;

   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;

   modport slave (
      input  if_req, if_addr, if_cancel, mem_read, mem_write, mem_type, mem_addr, mem_wdata, ram_din,
      output if_done, if_inst, mem_done, mem_rdata, stall_req, ram_dout, ram_a, ram_wr
   );

   modport master (
      output if_req, if_addr, if_cancel, mem_read, mem_write, mem_type, mem_addr, mem_wdata, ram_din,
      input  if_done, if_inst, mem_done, mem_rdata, stall_req, ram_dout, ram_a, ram_wr
   );

endinterface

// File: rtl/mem_byte_assembler.sv
// Collects RAM bytes into little-endian lanes of a zero-filled 32-bit word.
module mem_byte_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_cap,
   input  logic [1:0]  i_lane,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word
);

   logic [31:0] r_lanes;
   logic [31:0] w_word;

   // o_word already includes the byte being captured this cycle
   always_comb begin
      w_word = r_lanes;
      if (i_cap)
         w_word[8*i_lane +: 8] = i_byte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_lanes <= '0;
      else if (i_clear)
         r_lanes <= '0;
      else if (i_cap)
         r_lanes <= w_word;
   end

   assign o_word = w_word;

endmodule

// File: rtl/mem_ctrl.sv
// Serialises IF fetches and MEM loads/stores onto a byte-wide synchronous RAM.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned WORD_BYTES = 4
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   state_e            r_state, w_state_nxt;
   owner_e            r_owner, w_owner_nxt;
   logic [2:0]        r_cnt, w_cnt_nxt;
   logic [2:0]        r_len, w_len_nxt;
   logic [ADDR_W-1:0] r_ram_a, w_ram_a_nxt;
   logic [31:0]       r_wdata, w_wdata_nxt;
   logic [7:0]        r_ram_dout, w_ram_dout_nxt;
   logic              r_ram_wr, w_ram_wr_nxt;
   logic              r_if_done, w_if_done_nxt;
   logic              r_mem_done, w_mem_done_nxt;
   logic [31:0]       r_if_inst, w_if_inst_nxt;
   logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
   logic              w_asm_clr, w_asm_cap;
   logic [1:0]        w_lane;
   logic [31:0]       w_word;

   assign w_lane = 2'(r_cnt - 3'd1);

   mem_byte_assembler u_asm (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_asm_clr),
      .i_cap   (w_asm_cap),
      .i_lane  (w_lane),
      .i_byte  (bus.ram_din),
      .o_word  (w_word)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_cnt_nxt       = r_cnt;
      w_len_nxt       = r_len;
      w_ram_a_nxt     = r_ram_a;
      w_wdata_nxt     = r_wdata;
      w_ram_dout_nxt  = r_ram_dout;
      w_ram_wr_nxt    = 1'b0;
      w_if_done_nxt   = 1'b0;
      w_mem_done_nxt  = 1'b0;
      w_if_inst_nxt   = r_if_inst;
      w_mem_rdata_nxt = r_mem_rdata;
      w_asm_clr       = 1'b0;
      w_asm_cap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               w_owner_nxt = OWN_MEM;
               w_len_nxt   = len_of(mem_type_e'(bus.mem_type));
               w_cnt_nxt   = '0;
               w_ram_a_nxt = bus.mem_addr;
               w_asm_clr   = 1'b1;
               if (bus.mem_write) begin
                  w_state_nxt    = S_WR;
                  w_ram_wr_nxt   = 1'b1;
                  w_ram_dout_nxt = bus.mem_wdata[7:0];
                  w_wdata_nxt    = {8'h00, bus.mem_wdata[31:8]};
               end else begin
                  w_state_nxt = S_RD;
               end
            end else if (bus.if_req && !bus.if_cancel) begin
               w_owner_nxt = OWN_IF;
               w_len_nxt   = 3'(WORD_BYTES);
               w_cnt_nxt   = '0;
               w_ram_a_nxt = bus.if_addr;
               w_asm_clr   = 1'b1;
               w_state_nxt = S_RD;
            end
         end
         S_RD: begin
            if (r_owner == OWN_IF && bus.if_cancel) begin
               w_state_nxt = S_IDLE;
            end else begin
               // cycle i captures byte i-1; address stops advancing at the last byte
               w_asm_cap = (r_cnt >= 3'(RAM_LAT));
               if (r_cnt == r_len) begin
                  w_state_nxt = S_DONE;
                  if (r_owner == OWN_IF) begin
                     w_if_done_nxt = 1'b1;
                     w_if_inst_nxt = w_word;
                  end else begin
                     w_mem_done_nxt  = 1'b1;
                     w_mem_rdata_nxt = w_word;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 3'd1;
                  if (r_cnt < r_len - 3'd1)
                     w_ram_a_nxt = r_ram_a + ADDR_W'(1);
               end
            end
         end
         S_WR: begin
            if (r_cnt == r_len - 3'd1) begin
               w_state_nxt    = S_DONE;
               w_mem_done_nxt = 1'b1;
            end else begin
               w_cnt_nxt      = r_cnt + 3'd1;
               w_ram_a_nxt    = r_ram_a + ADDR_W'(1);
               w_ram_wr_nxt   = 1'b1;
               w_ram_dout_nxt = r_wdata[7:0];
               w_wdata_nxt    = {8'h00, r_wdata[31:8]};
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_owner     <= OWN_IF;
         r_cnt       <= '0;
         r_len       <= '0;
         r_ram_a     <= '0;
         r_wdata     <= '0;
         r_ram_dout  <= '0;
         r_ram_wr    <= 1'b0;
         r_if_done   <= 1'b0;
         r_mem_done  <= 1'b0;
         r_if_inst   <= '0;
         r_mem_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_cnt       <= w_cnt_nxt;
         r_len       <= w_len_nxt;
         r_ram_a     <= w_ram_a_nxt;
         r_wdata     <= w_wdata_nxt;
         r_ram_dout  <= w_ram_dout_nxt;
         r_ram_wr    <= w_ram_wr_nxt;
         r_if_done   <= w_if_done_nxt;
         r_mem_done  <= w_mem_done_nxt;
         r_if_inst   <= w_if_inst_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
      end
   end

   // a flush arriving in the DONE cycle still has to swallow the fetch pulse
   assign bus.if_done   = r_if_done & ~bus.if_cancel;
   assign bus.if_inst   = r_if_inst;
   assign bus.mem_done  = r_mem_done;
   assign bus.mem_rdata = r_mem_rdata;
   assign bus.stall_req = (bus.mem_read | bus.mem_write) & ~r_mem_done;
   assign bus.ram_a     = r_ram_a;
   assign bus.ram_dout  = r_ram_dout;
   assign bus.ram_wr    = r_ram_wr;

endmodule
